// File: rtl/ring_mem_responder.sv
// Generic FIFO: pre-edge full/empty, simultaneous push/pop allowed, pointers wrap modulo DEPTH.
// Latency: a pushed word is visible at popData the cycle after the push edge.
// Backpressure: pushes while full are ignored unless a real pop frees the slot in the same cycle.
module ringFifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             popOk;
    logic             pushOk;

    // A pop only counts when there is data; only such a pop can make room for a push while full.
    assign popOk   = pop && (count != '0);
    assign pushOk  = push && ((count != FULL_COUNT) || popOk);
    assign popData = mem[rdPtr];

    // Storage array, no reset needed: occupancy decides what is valid.
    always_ff @(posedge clock) begin
        if (pushOk) mem[wrPtr] <= pushData;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) wrPtr <= (wrPtr == LAST_PTR) ? '0 : wrPtr + 1'b1;
            if (popOk)  rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + 1'b1;
            if (pushOk && !popOk)      count <= count + 1'b1;
            else if (!pushOk && popOk) count <= count - 1'b1;
        end
    end
endmodule

// Ring memory responder: consumes Address/WriteData slots, issues line commands, streams read lines back.
// Latency: ring slot in -> out 1 cycle; read line returned as 8 registered words after the 8th memory word.
// Backpressure: ring cannot be stalled, so full FIFOs drop and set sticky overflow; mem side uses valid/ready.
module ring_mem_responder #(
    parameter int CMD_DEPTH = 4,
    parameter int WD_DEPTH  = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] RingIn,
    input  logic [3:0]  SlotTypeIn,
    input  logic [3:0]  SrcDestIn,
    output logic [31:0] RingOut,
    output logic [3:0]  SlotTypeOut,
    output logic [3:0]  SrcDestOut,
    output logic [31:0] RDreturn,
    output logic [3:0]  RDdest,
    output logic        mem_cmd_valid,
    input  logic        mem_cmd_ready,
    output logic        mem_cmd_write,
    output logic [27:0] mem_cmd_addr,
    output logic [31:0] mem_wd,
    input  logic        mem_wd_pop,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_valid,
    output logic        mem_rd_ready,
    output logic        overflow
);
    // Token (1) and any other type are forwarded untouched, so only these need names.
    localparam logic [3:0] SLOT_NULL  = 4'd7;
    localparam logic [3:0] SLOT_ADDR  = 4'd2;
    localparam logic [3:0] SLOT_WDATA = 4'd3;

    localparam int CW  = $clog2(CMD_DEPTH) + 1;
    localparam int WCW = $clog2(WD_DEPTH) + 1;
    localparam logic [CW-1:0]  CMD_FULL = CW'(CMD_DEPTH);
    localparam logic [WCW-1:0] WD_FULL  = WCW'(WD_DEPTH);

    typedef enum logic [1:0] {RIDLE, FILL, SEND} rstate_t;

    rstate_t        state;
    logic [2:0]     rcnt;
    logic [2:0]     kIdx;
    logic [31:0]    lineBuf [8];

    logic           isAddr;
    logic           isWdata;
    logic           addrRead;
    logic           enoughWords;

    logic [CW-1:0]  cmdCount;
    logic [32:0]    cmdHead;
    logic           cmdEmpty;
    logic           cmdFull;
    logic           cmdPush;
    logic           cmdPushOk;
    logic           cmdPop;

    logic [CW-1:0]  tagCount;
    logic [3:0]     tagHead;
    logic           tagEmpty;
    logic           tagFull;
    logic           tagPush;
    logic           tagPop;

    logic [WCW-1:0] wdCount;
    logic [WCW-1:0] claimCnt;
    logic           wdEmpty;
    logic           wdFull;
    logic           wdPopOk;
    logic           acceptWrite;
    logic           protoErr;

    assign isAddr   = (SlotTypeIn == SLOT_ADDR);
    assign isWdata  = (SlotTypeIn == SLOT_WDATA);
    assign addrRead = RingIn[28];

    assign cmdEmpty = (cmdCount == '0);
    assign cmdFull  = (cmdCount == CMD_FULL);
    assign tagEmpty = (tagCount == '0);
    assign tagFull  = (tagCount == CMD_FULL);
    assign wdEmpty  = (wdCount == '0);
    assign wdFull   = (wdCount == WD_FULL);
    assign wdPopOk  = mem_wd_pop && !wdEmpty;

    // A write needs a full line of data that no earlier write has already claimed.
    assign enoughWords = {1'b0, wdCount} >= ({1'b0, claimCnt} + (WCW+1)'(8));

    assign cmdPush     = isAddr && (addrRead || enoughWords);
    assign cmdPushOk   = cmdPush && (!cmdFull || cmdPop);
    assign acceptWrite = cmdPushOk && !addrRead;

    // Reads are held back while no tag slot is free, so a popped read always has a tag home.
    assign mem_cmd_valid = !cmdEmpty && (cmdHead[32] || !tagFull);
    assign mem_cmd_write = cmdHead[32];
    assign mem_cmd_addr  = cmdHead[31:4];
    assign cmdPop        = mem_cmd_valid && mem_cmd_ready;
    assign tagPush       = cmdPop && !cmdHead[32];
    assign tagPop        = (state == SEND) && (kIdx == 3'd7);

    assign protoErr = (isWdata && wdFull && !wdPopOk)
                    || (cmdPush && !cmdPushOk)
                    || (isAddr && !addrRead && !enoughWords)
                    || (mem_wd_pop && wdEmpty);

    ringFifo #(.WIDTH(33), .DEPTH(CMD_DEPTH)) cmdFifo (
        .clock    (clock),
        .reset    (reset),
        .push     (cmdPush),
        .pushData ({~RingIn[28], RingIn[27:0], SrcDestIn}),
        .pop      (cmdPop),
        .popData  (cmdHead),
        .count    (cmdCount)
    );

    ringFifo #(.WIDTH(4), .DEPTH(CMD_DEPTH)) tagFifo (
        .clock    (clock),
        .reset    (reset),
        .push     (tagPush),
        .pushData (cmdHead[3:0]),
        .pop      (tagPop),
        .popData  (tagHead),
        .count    (tagCount)
    );

    ringFifo #(.WIDTH(32), .DEPTH(WD_DEPTH)) wdFifo (
        .clock    (clock),
        .reset    (reset),
        .push     (isWdata),
        .pushData (RingIn),
        .pop      (mem_wd_pop),
        .popData  (mem_wd),
        .count    (wdCount)
    );

    // Ring stage: memory slots are swallowed and replaced by Null, everything else is forwarded.
    always_ff @(posedge clock) begin
        if (reset || isAddr || isWdata) begin
            SlotTypeOut <= SLOT_NULL;
            RingOut     <= '0;
            SrcDestOut  <= '0;
        end else begin
            SlotTypeOut <= SlotTypeIn;
            RingOut     <= RingIn;
            SrcDestOut  <= SrcDestIn;
        end
    end

    // Claimed-word tracking: accepted writes reserve 8 words, each real pop releases one reservation.
    always_ff @(posedge clock) begin
        if (reset) begin
            claimCnt <= '0;
        end else begin
            claimCnt <= claimCnt
                      + (acceptWrite ? WCW'(8) : '0)
                      - ((wdPopOk && (claimCnt != '0)) ? WCW'(1) : '0);
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset)         overflow <= 1'b0;
        else if (protoErr) overflow <= 1'b1;
    end

    // Line buffer capture; contents are only meaningful once rcnt has counted a full line.
    always_ff @(posedge clock) begin
        if (state == FILL && mem_rd_valid) lineBuf[rcnt] <= mem_rd_data;
    end

    // Read-return FSM: collect one 8-word line, then replay it to the tagged core on consecutive cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RIDLE;
            rcnt         <= '0;
            kIdx         <= '0;
            mem_rd_ready <= 1'b0;
            RDreturn     <= '0;
            RDdest       <= '0;
        end else begin
            RDreturn <= '0;
            RDdest   <= '0;
            case (state)
                RIDLE: begin
                    if (!tagEmpty) begin
                        state        <= FILL;
                        rcnt         <= '0;
                        mem_rd_ready <= 1'b1;
                    end
                end
                FILL: begin
                    if (mem_rd_valid) begin
                        rcnt <= rcnt + 3'd1;
                        if (rcnt == 3'd7) begin
                            state        <= SEND;
                            kIdx         <= '0;
                            mem_rd_ready <= 1'b0;
                        end
                    end
                end
                SEND: begin
                    RDreturn <= lineBuf[kIdx];
                    RDdest   <= tagHead;
                    kIdx     <= kIdx + 3'd1;
                    if (kIdx == 3'd7) state <= RIDLE;
                end
                default: begin
                    state        <= RIDLE;
                    mem_rd_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ring_mem_responder.sv
// Bench for ring_mem_responder: directed slots, scoreboard queues, one negedge monitor.
// Latency: ring checks are tagged with the cycle their output must appear in.
// Backpressure: memory side driven by stimulus tasks with bounded waits on mem_rd_ready.
module tb_ring_mem_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] RingIn = '0;
    logic [3:0]  SlotTypeIn = 4'd7;
    logic [3:0]  SrcDestIn = '0;
    logic [31:0] RingOut;
    logic [3:0]  SlotTypeOut;
    logic [3:0]  SrcDestOut;
    logic [31:0] RDreturn;
    logic [3:0]  RDdest;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready = 1'b0;
    logic        mem_cmd_write;
    logic [27:0] mem_cmd_addr;
    logic [31:0] mem_wd;
    logic        mem_wd_pop = 1'b0;
    logic [31:0] mem_rd_data = '0;
    logic        mem_rd_valid = 1'b0;
    logic        mem_rd_ready;
    logic        overflow;

    ring_mem_responder #(.CMD_DEPTH(4), .WD_DEPTH(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .RingIn        (RingIn),
        .SlotTypeIn    (SlotTypeIn),
        .SrcDestIn     (SrcDestIn),
        .RingOut       (RingOut),
        .SlotTypeOut   (SlotTypeOut),
        .SrcDestOut    (SrcDestOut),
        .RDreturn      (RDreturn),
        .RDdest        (RDdest),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_write (mem_cmd_write),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_wd        (mem_wd),
        .mem_wd_pop    (mem_wd_pop),
        .mem_rd_data   (mem_rd_data),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_ready  (mem_rd_ready),
        .overflow      (overflow)
    );

    always #5 clock = ~clock;

    localparam logic [3:0]  T_NULL  = 4'd7;
    localparam logic [3:0]  T_TOKEN = 4'd1;
    localparam logic [3:0]  T_ADDR  = 4'd2;
    localparam logic [3:0]  T_WDATA = 4'd3;
    localparam logic [39:0] NULL_SLOT = {4'd7, 32'h0, 4'h0};

    typedef struct {
        int          cyc;
        logic [39:0] slot;
    } ringExp_t;

    ringExp_t    ringQ[$];
    logic [28:0] cmdQ[$];
    logic [35:0] rdQ[$];
    logic [31:0] wdQ[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic failNote(input string name, input string why);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents something.
    ringExp_t    re;
    logic [28:0] ce;
    logic [35:0] rde;
    logic [31:0] we;
    always @(negedge clock) begin
        while (ringQ.size() > 0 && ringQ[0].cyc <= cyc) begin
            re = ringQ.pop_front();
            if (re.cyc < cyc) failNote("ring", "slot output window missed");
            else check("ring", 64'({SlotTypeOut, RingOut, SrcDestOut}), 64'(re.slot));
        end
        if (mem_cmd_valid && mem_cmd_ready) begin
            if (cmdQ.size() == 0) failNote("cmd", "unexpected command accepted");
            else begin
                ce = cmdQ.pop_front();
                check("cmd", 64'({mem_cmd_write, mem_cmd_addr}), 64'(ce));
            end
        end
        if (RDdest != 4'd0) begin
            if (rdQ.size() == 0) failNote("rd", "unexpected read-return word");
            else begin
                rde = rdQ.pop_front();
                check("rd", 64'({RDdest, RDreturn}), 64'(rde));
            end
        end
        if (mem_wd_pop && wdQ.size() > 0) begin
            we = wdQ.pop_front();
            check("wd", 64'(mem_wd), 64'(we));
        end
    end

    task automatic sendSlot(input logic [3:0] t, input logic [31:0] d, input logic [3:0] s,
                            input logic [39:0] expSlot);
        ringExp_t e;
        @(posedge clock); #1;
        SlotTypeIn = t;
        RingIn     = d;
        SrcDestIn  = s;
        e.cyc  = cyc + 1;
        e.slot = expSlot;
        ringQ.push_back(e);
    endtask

    task automatic passThru(input logic [3:0] t, input logic [31:0] d, input logic [3:0] s);
        sendSlot(t, d, s, {t, d, s});
    endtask

    task automatic consume(input logic [3:0] t, input logic [31:0] d, input logic [3:0] s);
        sendSlot(t, d, s, NULL_SLOT);
    endtask

    task automatic idleSlot();
        @(posedge clock); #1;
        SlotTypeIn = T_NULL;
        RingIn     = '0;
        SrcDestIn  = '0;
    endtask

    task automatic doReset(input int cycles);
        @(posedge clock); #1;
        reset        = 1'b1;
        mem_rd_valid = 1'b0;
        mem_wd_pop   = 1'b0;
        repeat (cycles) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Memory model: offers base..base+7, expecting only the first nExp words to come back out.
    task automatic returnLine(input logic [31:0] base, input logic [3:0] dest, input int nExp);
        int n;
        for (int i = 0; i < nExp; i++) rdQ.push_back({dest, base + 32'(i)});
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            mem_rd_valid = 1'b1;
            mem_rd_data  = base + 32'(i);
            n = 0;
            @(negedge clock);
            while (!mem_rd_ready && n < 100) begin
                @(negedge clock);
                n++;
            end
            if (!mem_rd_ready) begin
                failNote("rd_ready", "timed out waiting for mem_rd_ready");
                break;
            end
        end
        @(posedge clock); #1;
        mem_rd_valid = 1'b0;
    endtask

    task automatic popWords(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            mem_wd_pop = 1'b1;
        end
        @(posedge clock); #1;
        mem_wd_pop = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((ringQ.size() + cmdQ.size() + rdQ.size() + wdQ.size()) > 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("drain", 64'(ringQ.size() + cmdQ.size() + rdQ.size() + wdQ.size()), 64'(0));
    endtask

    initial begin
        int n;
        // Reset state.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_ring", 64'({SlotTypeOut, RingOut, SrcDestOut}), 64'(NULL_SLOT));
        check("rst_rd", 64'({RDdest, RDreturn}), 64'(0));
        check("rst_cmd_valid", 64'(mem_cmd_valid), 64'(0));
        check("rst_rd_ready", 64'(mem_rd_ready), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        mem_cmd_ready = 1'b1;

        // Token and an unknown (Message) slot pass unchanged.
        passThru(T_TOKEN, 32'h0000_0003, 4'h2);
        passThru(4'd5, 32'hDEAD_BEEF, 4'h9);
        passThru(4'd0, 32'h1234_5678, 4'hF);
        idleSlot();
        waitDrain();

        // Single read line to core 3.
        consume(T_ADDR, 32'h1000_0040, 4'd3);
        cmdQ.push_back({1'b0, 28'h000_0040});
        idleSlot();
        returnLine(32'h0000_00A0, 4'd3, 8);
        waitDrain();
        @(negedge clock);
        check("rd_idle", 64'({RDdest, RDreturn}), 64'(0));

        // Write line: 8 data words then the write address; all 9 slots become Null.
        for (int i = 0; i < 8; i++) consume(T_WDATA, 32'(i), 4'd0);
        consume(T_ADDR, 32'h0000_0080, 4'd5);
        cmdQ.push_back({1'b1, 28'h000_0080});
        idleSlot();
        waitDrain();
        for (int i = 0; i < 8; i++) wdQ.push_back(32'(i));
        popWords(8);
        waitDrain();
        @(negedge clock);
        check("wr_no_overflow", 64'(overflow), 64'(0));
        popWords(1);
        @(negedge clock);
        check("pop_empty_overflow", 64'(overflow), 64'(1));

        // Write address with only 4 words buffered is dropped.
        doReset(2);
        @(negedge clock);
        check("overflow_cleared", 64'(overflow), 64'(0));
        for (int i = 0; i < 4; i++) consume(T_WDATA, 32'h100 + 32'(i), 4'd0);
        consume(T_ADDR, 32'h0000_0100, 4'd5);
        idleSlot();
        repeat (4) @(negedge clock);
        check("short_wr_overflow", 64'(overflow), 64'(1));
        check("short_wr_no_cmd", 64'(mem_cmd_valid), 64'(0));
        waitDrain();

        // Five reads into a 4-deep command FIFO while memory stalls.
        doReset(2);
        mem_cmd_ready = 1'b0;
        for (int s = 1; s <= 5; s++) consume(T_ADDR, 32'h1000_0000 | 32'(s * 16), 4'(s));
        idleSlot();
        @(negedge clock);
        check("cmd_full_overflow", 64'(overflow), 64'(1));
        check("cmd_full_valid", 64'(mem_cmd_valid), 64'(1));
        waitDrain();
        doReset(2);
        @(negedge clock);
        check("cmd_empty_after_reset", 64'(mem_cmd_valid), 64'(0));

        // Two reads returned in command order: core 2 then core 4.
        mem_cmd_ready = 1'b1;
        consume(T_ADDR, 32'h1000_0200, 4'd2);
        consume(T_ADDR, 32'h1000_0400, 4'd4);
        cmdQ.push_back({1'b0, 28'h000_0200});
        cmdQ.push_back({1'b0, 28'h000_0400});
        idleSlot();
        returnLine(32'h0000_00B0, 4'd2, 8);
        returnLine(32'h0000_00C0, 4'd4, 8);
        waitDrain();

        // Reset lands while the burst is at k=3: only k=0..2 may ever be seen.
        consume(T_ADDR, 32'h1000_0300, 4'd7);
        cmdQ.push_back({1'b0, 28'h000_0300});
        idleSlot();
        returnLine(32'h0000_00D0, 4'd7, 3);
        n = 0;
        @(negedge clock);
        while (RDdest == 4'd0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("send_started", 64'(RDdest), 64'(7));
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("abort_rd", 64'({RDdest, RDreturn}), 64'(0));
        check("abort_overflow", 64'(overflow), 64'(0));
        check("abort_cmd_valid", 64'(mem_cmd_valid), 64'(0));
        check("abort_rd_ready", 64'(mem_rd_ready), 64'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("abort_partial_seen", 64'(rdQ.size()), 64'(0));
        check("abort_idle_rd_ready", 64'(mem_rd_ready), 64'(0));

        waitDrain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
